// File: rtl/cpu0_mem_arbiter_if.sv
// Request/grant/valid bundle between the CPU0 requesters, the arbiter and the memory port.
// slave = arbiter view; master = requester and memory side.
interface cpu0_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic [DW-1:0] i_rdata;
    logic          i_valid;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic [DW-1:0] d_rdata;
    logic          d_valid;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_gnt, i_rdata, i_valid, d_gnt, d_rdata, d_valid,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_gnt, i_rdata, i_valid, d_gnt, d_rdata, d_valid,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cpu0_mem_arbiter.sv
// Round-robin arbiter sharing the CPU0 memory port between fetch and data; gnt comb, valid at ack+1.
// No grants while an access is outstanding; optional mem_ack timeout via CPU0_ARB_TIMEOUT_EN.
module cpu0_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    cpu0_mem_arbiter_if.slave   bus,
    output logic                err
);
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {SRC_I, SRC_D} src_t;

    state_t        state, state_nxt;
    src_t          owner, last;
    logic          win_i, win_d, grant, done, timeout;
    logic [DW-1:0] rdata_in;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Grants are gated by reset_n so nothing is accepted while the block is held in reset.
    always_comb begin
        state_nxt = state;
        win_i     = 1'b0;
        win_d     = 1'b0;
        done      = 1'b0;
        bus.i_gnt = 1'b0;
        bus.d_gnt = 1'b0;
        case (state)
            IDLE: begin
                if (reset_n) begin
                    win_d = bus.d_req && (!bus.i_req || last == SRC_I);
                    win_i = bus.i_req && !win_d;
                end
                bus.i_gnt = win_i;
                bus.d_gnt = win_d;
                if (win_i || win_d) state_nxt = BUSY;
            end
            BUSY: begin
                done = bus.mem_ack || timeout;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant    = win_i || win_d;
    assign rdata_in = bus.mem_ack ? bus.mem_rdata : DW'(32'hDEADBEEF);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.i_valid   <= 1'b0;
            bus.d_valid   <= 1'b0;
            owner         <= SRC_I;
            last          <= SRC_I;
        end else begin
            bus.i_valid <= done && owner == SRC_I;
            bus.d_valid <= done && owner == SRC_D;
            if (grant) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= win_d && bus.d_we;
                bus.mem_addr <= win_d ? bus.d_addr : bus.i_addr;
                if (win_d) bus.mem_wdata <= bus.d_wdata;
                owner <= win_d ? SRC_D : SRC_I;
                last  <= win_d ? SRC_D : SRC_I;
            end
            if (done) begin
                bus.mem_req <= 1'b0;
                bus.mem_we  <= 1'b0;
                if (owner == SRC_I)   bus.i_rdata <= rdata_in;
                else if (!bus.mem_we) bus.d_rdata <= rdata_in;
            end
        end
    end

`ifdef CPU0_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt;

    // Fires on the TIMEOUT-th consecutive BUSY cycle without ack; an ack in that cycle wins.
    assign timeout = (state == BUSY) && !bus.mem_ack && (to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (grant)                                to_cnt <= '0;
            else if (state == BUSY && !bus.mem_ack)   to_cnt <= to_cnt + 1'b1;
            if (timeout)                              err    <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0 & (TIMEOUT == 0);
`endif
endmodule

// File: doc/cpu0_mem_arbiter.md
Name: cpu0_mem_arbiter

Overview:
- Shares the single CPU0 memory port between two requesters: instruction fetch (I) and load/store data access (D).
- Sits between the multi-cycle CPU0 core and the memory model. Serializes 32-bit word accesses with a req/gnt/valid handshake per requester and a req/ack handshake to memory.
- Round-robin arbitration guarantees neither fetch nor data access starves. A pending data access wins the first conflict after reset.

Parameters:
- AW, 32, address width (byte address; word accesses only, addr[1:0] passed through unchanged)
- DW, 32, data width
- TIMEOUT, 16, cycles to wait for mem_ack before error completion (used only with CPU0_ARB_TIMEOUT_EN)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  AW  fetch address (PC)
- i_gnt  out  1  fetch accepted (combinational, 1-cycle pulse)
- i_rdata  out  DW  fetched instruction word
- i_valid  out  1  fetch complete, 1-cycle pulse
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1=store (ST), 0=load (LD)
- d_addr  in  AW  data address (R[rb]+cx16)
- d_wdata  in  DW  store data
- d_gnt  out  1  data accepted (combinational, 1-cycle pulse)
- d_rdata  out  DW  load result
- d_valid  out  1  data access complete, 1-cycle pulse
- mem_req  out  1  memory access active (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  AW  memory address (registered)
- mem_wdata  out  DW  memory write data (registered)
- mem_ack  in  1  memory completes access this cycle
- mem_rdata  in  DW  read data, valid with mem_ack
- err  out  1  timeout error flag, sticky until reset (tied 0 when feature off)

Behaviour:
- States: IDLE, BUSY. The owner register (I/D) records the current grantee. The last register records the previous grantee and resets to I, so D wins the first conflict.
- Reset values:
  - state = IDLE
  - all *_gnt, *_valid, mem_req, mem_we and err = 0
  - mem_addr, mem_wdata, i_rdata and d_rdata = 0
- IDLE, no request: outputs idle; stay in IDLE.
- IDLE, exactly one request: that requester wins.
- IDLE, both requests: the requester not equal to last wins.
- On a win:
  - Assert the winner's gnt in the same cycle.
  - Latch addr, we and wdata into mem_* (an I access forces mem_we = 0).
  - Set mem_req = 1 next cycle, go to BUSY, and set owner and last to the winner.
- BUSY:
  - Hold mem_req and all mem_* stable until mem_ack.
  - Requests are not granted while in BUSY.
- On mem_ack in BUSY:
  - Next cycle: mem_req = 0, mem_we = 0, state = IDLE, owner's valid = 1 for one cycle.
  - For a read, the owner's rdata captures mem_rdata.
  - For a store, d_rdata is left unchanged.
- A new grant may occur in the same cycle the previous valid pulses.
- Latency:
  - request in IDLE at cycle 0 → gnt at cycle 0 → mem_req from cycle 1 → valid at cycle k+1, where k is the mem_ack cycle.
  - Zero-wait memory (ack at cycle 1) gives valid at cycle 2, i.e. one access per 2 cycles.
- mem_ack while mem_req = 0 is ignored.
- A requester dropping req before gnt is legal; nothing is granted to it.
- Reset asserted mid-BUSY aborts the access immediately: all outputs return to their reset values and no valid is issued.

Optional Feature:
- Macro: CPU0_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When the counter reaches TIMEOUT, the access completes as if acked: owner's valid pulses, owner's rdata = 32'hDEADBEEF for reads, err is set sticky, state goes to IDLE.
  - mem_ack arriving in the same cycle as the timeout takes precedence: normal completion, no err.
- Undefined: no counter; BUSY waits indefinitely; err tied 0.

Test Plan:
- Reset with i_req = 1 held, then release reset_n → no i_gnt while reset_n = 0; i_gnt in the first cycle after release; mem_addr = 0.
- Fetch-only, zero-wait memory returning 32'h001F0018 at address 0 → i_gnt cycle 0, mem_req cycle 1, i_valid cycle 2 with i_rdata = 32'h001F0018.
- i_req (addr 4) and d_req (load, addr 32'h1C) asserted together after reset → D granted first, d_rdata = 1; then I granted; repeating the conflict alternates I/D.
- Store d_we = 1, addr 32'h20, wdata 55, mem_ack delayed 3 cycles → mem_we = 1 and mem_wdata = 55 stable for 3 cycles; d_valid one cycle after ack; d_rdata unchanged.
- reset_n pulsed low during BUSY → mem_req drops immediately, no valid pulse, next request is served normally.
- With CPU0_ARB_TIMEOUT_EN, TIMEOUT = 16, memory never acks a fetch → i_valid after 16 BUSY cycles, i_rdata = 32'hDEADBEEF, err = 1 and held until reset.
